// File: rtl/drum_voice_scheduler.sv
// drum_voice_scheduler
//   Time-multiplexes one single-port sample BRAM between NUM_VOICES drum
//   playback voices and a sample-loader write port. Each AC97 ready strobe
//   starts a frame: every voice slot gets a READ cycle (address out) and an
//   ACC cycle (registered BRAM data back). Active voices are summed, and each
//   one's address advances. The mixed word is scaled up to OUT_W and
//   published with a one-cycle mix_valid.
//
// Ports
//   clock, reset          system clock, asynchronous active-low reset
//   ready                 one-cycle strobe that starts a mix frame
//   trigger               per-voice start/restart pulse (accepted in any state)
//   voice_start/end       packed per-voice sample range, end inclusive
//   ld_req/addr/data      loader write request, held until ld_ack
//   ld_ack                loader write performed this cycle (IDLE only)
//   mem_addr/we/din       BRAM command port
//   mem_dout              BRAM read data, one cycle after the address
//   mix_out, mix_valid    signed mixed sample and its update pulse
//   active                per-voice playing flags
//   busy                  frame in progress
//   ready_missed          ready arrived while a frame was running
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for ready; loader writes are served here
// READ  | present address of voice v (bus idle if voice v is inactive)
// ACC   | accumulate mem_dout for voice v, advance its address
// DONE  | mix_out/mix_valid visible; return to IDLE
module drum_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ready,
  input  logic [NUM_VOICES-1:0]        trigger,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_start,
  input  logic [NUM_VOICES*ADDR_W-1:0] voice_end,
  input  logic                         ld_req,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  output logic                         ld_ack,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [DATA_W-1:0]            mem_din,
  input  logic [DATA_W-1:0]            mem_dout,
  output logic [OUT_W-1:0]             mix_out,
  output logic                         mix_valid,
  output logic [NUM_VOICES-1:0]        active,
  output logic                         busy,
  output logic                         ready_missed
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int ACC_W = DATA_W + VW;
  localparam int SHIFT = OUT_W - ACC_W;
  localparam logic [VW-1:0] V_LAST = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, READ, ACC, DONE} state_t;

  state_t                    state;
  logic [VW-1:0]             v;
  logic signed [ACC_W-1:0]   acc;
  logic                      rd_active;
  logic                      rd_trig;
  logic [ADDR_W-1:0]         addr    [NUM_VOICES];
  logic [ADDR_W-1:0]         start_a [NUM_VOICES];
  logic [ADDR_W-1:0]         end_a   [NUM_VOICES];

  logic signed [ACC_W-1:0]   smp_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [OUT_W-1:0]   acc_wide;
  logic signed [OUT_W-1:0]   mix_next;
  logic                      ld_go;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      start_a[i] = voice_start[i*ADDR_W +: ADDR_W];
      end_a[i]   = voice_end[i*ADDR_W +: ADDR_W];
    end
  end

  // Contribution is gated by the activity captured at READ, so a voice that
  // was idle when its slot was read adds nothing even if triggered since.
  always_comb begin
    smp_ext  = rd_active ? {{VW{mem_dout[DATA_W-1]}}, mem_dout} : '0;
    acc_sum  = acc + smp_ext;
    acc_wide = OUT_W'(acc_sum);
    mix_next = acc_wide <<< SHIFT;
  end

  // Loader owns the bus only in IDLE with no competing ready strobe.
  always_comb begin
    ld_go        = reset && (state == IDLE) && !ready && ld_req;
    ld_ack       = ld_go;
    mem_we       = ld_go;
    mem_din      = ld_go ? ld_data : '0;
    mem_addr     = '0;
    if (ld_go)
      mem_addr = ld_addr;
    else if ((state == READ) && active[v])
      mem_addr = addr[v];
    ready_missed = ready && busy;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      v         <= '0;
      acc       <= '0;
      rd_active <= 1'b0;
      rd_trig   <= 1'b0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      active    <= '0;
      for (int i = 0; i < NUM_VOICES; i++)
        addr[i] <= '0;
    end else begin
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            state <= READ;
            v     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          rd_active <= active[v];
          // A trigger landing on this READ already reloads the start address;
          // skipping the advance in ACC keeps that start sample for next frame.
          rd_trig   <= trigger[v];
          state     <= ACC;
        end
        ACC: begin
          acc <= acc_sum;
          if (rd_active && !rd_trig) begin
            if (addr[v] >= end_a[v])
              active[v] <= 1'b0;
            else
              addr[v] <= addr[v] + 1'b1;
          end
          if (v == V_LAST) begin
            state     <= DONE;
            mix_out   <= mix_next;
            mix_valid <= 1'b1;
          end else begin
            v     <= v + 1'b1;
            state <= READ;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Placed last so a trigger overrides an advance/clear in the same cycle.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (trigger[i]) begin
          addr[i]   <= start_a[i];
          active[i] <= 1'b1;
        end
      end
    end
  end

endmodule
